// File: rtl/tc_mem_pkg.sv
// tc_mem_pkg
// Shared types for the SDRAM port arbiter of the M68000 core.
// Contents: 2-bit port index type, port index constants, arbiter FSM state
// enum, and the round-robin pointer advance helper.
package tc_mem_pkg;

  typedef logic [1:0] port_idx_t;

  localparam port_idx_t PORT_DL  = 2'd0;
  localparam port_idx_t PORT_CPU = 2'd1;
  localparam port_idx_t PORT_SND = 2'd2;
  localparam port_idx_t PORT_GFX = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } arb_state_t;

  // The pointer moves to the port after the winner, wrapping gfx back to cpu.
  function automatic port_idx_t rr_next(input port_idx_t winner);
    port_idx_t nxt;
    if (winner == PORT_GFX) begin
      nxt = PORT_CPU;
    end else begin
      nxt = port_idx_t'(winner + 2'd1);
    end
    return nxt;
  endfunction

endpackage

// File: rtl/sdram_port_arbiter_rr_pick3.sv
// rr_pick3
// Combinational round-robin picker for the three read ports.
// Ports:
//   req   - request bits, bit0 = cpu (port 1), bit1 = sound (2), bit2 = gfx (3)
//   ptr   - port index (1..3) that has first claim this round
//   grant - one-hot grant, same bit order as req
//   valid - at least one request present
module rr_pick3
  import tc_mem_pkg::*;
(
  input  logic [2:0] req,
  input  logic [1:0] ptr,
  output logic [2:0] grant,
  output logic       valid
);

  // Search starting at ptr and wrapping; an out-of-range pointer behaves as cpu.
  always_comb begin
    grant = 3'b000;
    valid = |req;
    case (ptr)
      PORT_SND: begin
        if (req[1]) begin
          grant = 3'b010;
        end else if (req[2]) begin
          grant = 3'b100;
        end else if (req[0]) begin
          grant = 3'b001;
        end else begin
          grant = 3'b000;
        end
      end
      PORT_GFX: begin
        if (req[2]) begin
          grant = 3'b100;
        end else if (req[0]) begin
          grant = 3'b001;
        end else if (req[1]) begin
          grant = 3'b010;
        end else begin
          grant = 3'b000;
        end
      end
      default: begin
        if (req[0]) begin
          grant = 3'b001;
        end else if (req[1]) begin
          grant = 3'b010;
        end else if (req[2]) begin
          grant = 3'b100;
        end else begin
          grant = 3'b000;
        end
      end
    endcase
  end

endmodule

// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter
// Shares the single SDRAM controller port between ROM download writes
// (port 0, absolute priority) and three read requesters served round-robin
// (1 = 68000 program, 2 = Z80 sound ROM, 3 = gfx/sprite ROM). One
// transaction at a time: IDLE picks, BUSY waits for mem_ack, DONE pulses ack.
// Ports:
//   clk_96M, reset         - SDRAM clock, synchronous active-high reset
//   dl_active              - download in progress, only port 0 may be granted
//   p0_req/addr/wdata/be   - download write request, p0_ack completion pulse
//   pN_req/addr (N=1..3)   - read requests, pN_rdata/pN_ack read results
//   mem_req/we/addr/wdata/be - registered request to SDRAM controller
//   mem_ack/mem_rdata      - controller completion and read data
module sdram_port_arbiter
  import tc_mem_pkg::*;
#(
  parameter int AW = 24,
  parameter int DW = 16
) (
  input  logic            clk_96M,
  input  logic            reset,
  input  logic            dl_active,
  input  logic            p0_req,
  input  logic [AW-1:0]   p0_addr,
  input  logic [DW-1:0]   p0_wdata,
  input  logic [DW/8-1:0] p0_be,
  output logic            p0_ack,
  input  logic            p1_req,
  input  logic [AW-1:0]   p1_addr,
  output logic [DW-1:0]   p1_rdata,
  output logic            p1_ack,
  input  logic            p2_req,
  input  logic [AW-1:0]   p2_addr,
  output logic [DW-1:0]   p2_rdata,
  output logic            p2_ack,
  input  logic            p3_req,
  input  logic [AW-1:0]   p3_addr,
  output logic [DW-1:0]   p3_rdata,
  output logic            p3_ack,
  output logic            mem_req,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  output logic [DW/8-1:0] mem_be,
  input  logic            mem_ack,
  input  logic [DW-1:0]   mem_rdata
);

  arb_state_t    state_r;
  port_idx_t     grant_r;
  port_idx_t     rr_ptr_r;
  logic [2:0]    rd_req_s;
  logic [2:0]    pick_oh_s;
  logic          pick_valid_s;
  port_idx_t     pick_idx_s;
  logic [AW-1:0] pick_addr_s;

  assign rd_req_s = {p3_req, p2_req, p1_req};

  rr_pick3 u_pick (
    .req   (rd_req_s),
    .ptr   (rr_ptr_r),
    .grant (pick_oh_s),
    .valid (pick_valid_s)
  );

  // Turn the one-hot read grant into a port index and its address.
  always_comb begin
    pick_idx_s  = PORT_CPU;
    pick_addr_s = p1_addr;
    case (pick_oh_s)
      3'b010: begin
        pick_idx_s  = PORT_SND;
        pick_addr_s = p2_addr;
      end
      3'b100: begin
        pick_idx_s  = PORT_GFX;
        pick_addr_s = p3_addr;
      end
      default: begin
        pick_idx_s  = PORT_CPU;
        pick_addr_s = p1_addr;
      end
    endcase
  end

  // Arbiter FSM; every output toward requesters and controller is registered.
  always_ff @(posedge clk_96M) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      grant_r   <= PORT_DL;
      rr_ptr_r  <= PORT_CPU;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= {AW{1'b0}};
      mem_wdata <= {DW{1'b0}};
      mem_be    <= {(DW/8){1'b0}};
      p0_ack    <= 1'b0;
      p1_ack    <= 1'b0;
      p2_ack    <= 1'b0;
      p3_ack    <= 1'b0;
      p1_rdata  <= {DW{1'b0}};
      p2_rdata  <= {DW{1'b0}};
      p3_rdata  <= {DW{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          // Download writes win even when dl_active is low.
          if (p0_req) begin
            mem_req   <= 1'b1;
            mem_we    <= 1'b1;
            mem_addr  <= p0_addr;
            mem_wdata <= p0_wdata;
            mem_be    <= p0_be;
            grant_r   <= PORT_DL;
            state_r   <= ST_BUSY;
          end else if (!dl_active && pick_valid_s) begin
            mem_req   <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= pick_addr_s;
            mem_wdata <= {DW{1'b0}};
            mem_be    <= {(DW/8){1'b1}};
            grant_r   <= pick_idx_s;
            rr_ptr_r  <= rr_next(pick_idx_s);
            state_r   <= ST_BUSY;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_BUSY: begin
          // An ack in the first BUSY cycle is a valid completion.
          if (mem_ack) begin
            mem_req <= 1'b0;
            state_r <= ST_DONE;
            case (grant_r)
              PORT_DL: begin
                p0_ack <= 1'b1;
              end
              PORT_CPU: begin
                p1_ack   <= 1'b1;
                p1_rdata <= mem_rdata;
              end
              PORT_SND: begin
                p2_ack   <= 1'b1;
                p2_rdata <= mem_rdata;
              end
              PORT_GFX: begin
                p3_ack   <= 1'b1;
                p3_rdata <= mem_rdata;
              end
              default: begin
                p0_ack <= 1'b0;
              end
            endcase
          end else begin
            state_r <= ST_BUSY;
          end
        end
        ST_DONE: begin
          // The acked port still shows its old req here, so no arbitration.
          p0_ack  <= 1'b0;
          p1_ack  <= 1'b0;
          p2_ack  <= 1'b0;
          p3_ack  <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          mem_req <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// tb_sdram_port_arbiter
// Random requesters, a random-latency SDRAM controller with a small memory,
// and a transaction-level reference model of the arbitration rules. Every
// cycle the DUT outputs are compared with the model's expectation.
module tb_sdram_port_arbiter;

  localparam int AW = 24;
  localparam int DW = 16;

  logic          clk_96M = 1'b0;
  logic          reset;
  logic          dl_active;
  logic          p0_req, p1_req, p2_req, p3_req;
  logic [AW-1:0] p0_addr, p1_addr, p2_addr, p3_addr;
  logic [DW-1:0] p0_wdata;
  logic [1:0]    p0_be;
  logic          p0_ack, p1_ack, p2_ack, p3_ack;
  logic [DW-1:0] p1_rdata, p2_rdata, p3_rdata;
  logic          mem_req, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [1:0]    mem_be;
  logic          mem_ack;
  logic [DW-1:0] mem_rdata;

  sdram_port_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk_96M   (clk_96M),
    .reset     (reset),
    .dl_active (dl_active),
    .p0_req    (p0_req),
    .p0_addr   (p0_addr),
    .p0_wdata  (p0_wdata),
    .p0_be     (p0_be),
    .p0_ack    (p0_ack),
    .p1_req    (p1_req),
    .p1_addr   (p1_addr),
    .p1_rdata  (p1_rdata),
    .p1_ack    (p1_ack),
    .p2_req    (p2_req),
    .p2_addr   (p2_addr),
    .p2_rdata  (p2_rdata),
    .p2_ack    (p2_ack),
    .p3_req    (p3_req),
    .p3_addr   (p3_addr),
    .p3_rdata  (p3_rdata),
    .p3_ack    (p3_ack),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_be    (mem_be),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata)
  );

  always #5 clk_96M = ~clk_96M;

  int total = 0;
  int bad   = 0;

  // requester agents
  bit            ag_req  [4];
  bit            ag_done [4];
  logic [AW-1:0] ag_addr [4];
  logic [DW-1:0] ag_wdata;
  logic [1:0]    ag_be;
  int            raise_pct [4];
  int            renew_pct;
  int            rst_mode;
  int            dl_mode;

  // controller emulation
  logic [DW-1:0] mem_arr [16];
  bit            ctl_busy;
  int            ctl_cnt;

  // reference model
  int            m_owner;
  int            m_hold;
  int            m_ptr;
  bit            exp_req, exp_we, exp_chk;
  logic [AW-1:0] exp_addr;
  logic [DW-1:0] exp_wdata;
  logic [1:0]    exp_be;
  logic [3:0]    exp_ack;
  logic [DW-1:0] exp_rd [4];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic new_req(input int i);
    ag_req[i]  = 1'b1;
    ag_addr[i] = AW'($urandom_range(0, 15));
    if (i == 0) begin
      ag_wdata = DW'($urandom);
      ag_be    = 2'($urandom_range(0, 3));
    end
  endtask

  task automatic drive_ports();
    p0_req   = ag_req[0];
    p1_req   = ag_req[1];
    p2_req   = ag_req[2];
    p3_req   = ag_req[3];
    p0_addr  = ag_addr[0];
    p1_addr  = ag_addr[1];
    p2_addr  = ag_addr[2];
    p3_addr  = ag_addr[3];
    p0_wdata = ag_wdata;
    p0_be    = ag_be;
  endtask

  // Predict DUT outputs after the next edge from the inputs now being driven.
  task automatic model_step();
    int w;
    int p;
    exp_ack = 4'b0000;
    if (reset) begin
      exp_req   = 1'b0;
      exp_we    = 1'b0;
      exp_addr  = '0;
      exp_wdata = '0;
      exp_be    = 2'b00;
      exp_chk   = 1'b1;
      for (int i = 0; i < 4; i++) exp_rd[i] = '0;
      m_owner = -1;
      m_hold  = 0;
      m_ptr   = 1;
    end else if (m_owner >= 0) begin
      if (mem_ack) begin
        exp_ack[m_owner] = 1'b1;
        if (m_owner > 0) exp_rd[m_owner] = mem_rdata;
        exp_req = 1'b0;
        exp_chk = 1'b0;
        m_owner = -1;
        m_hold  = 1;
      end else begin
        exp_req = 1'b1;
      end
    end else if (m_hold > 0) begin
      m_hold--;
      exp_req = 1'b0;
      exp_chk = 1'b0;
    end else begin
      w = -1;
      if (ag_req[0]) begin
        w = 0;
      end else if (!dl_active) begin
        for (int k = 0; k < 3; k++) begin
          p = (m_ptr - 1 + k) % 3 + 1;
          if (ag_req[p] && w < 0) w = p;
        end
      end
      if (w >= 0) begin
        exp_req  = 1'b1;
        exp_chk  = 1'b1;
        exp_we   = (w == 0);
        exp_addr = ag_addr[w];
        exp_wdata = (w == 0) ? ag_wdata : '0;
        exp_be   = (w == 0) ? ag_be : 2'b11;
        if (w > 0) m_ptr = w % 3 + 1;
        m_owner = w;
      end else begin
        exp_req = 1'b0;
      end
    end
  endtask

  task automatic check_outputs();
    check_val("ack", {28'd0, p3_ack, p2_ack, p1_ack, p0_ack}, {28'd0, exp_ack});
    check_val("mem_req", {31'd0, mem_req}, {31'd0, exp_req});
    check_val("p1_rdata", {16'd0, p1_rdata}, {16'd0, exp_rd[1]});
    check_val("p2_rdata", {16'd0, p2_rdata}, {16'd0, exp_rd[2]});
    check_val("p3_rdata", {16'd0, p3_rdata}, {16'd0, exp_rd[3]});
    if (exp_chk) begin
      check_val("mem_we", {31'd0, mem_we}, {31'd0, exp_we});
      check_val("mem_addr", {8'd0, mem_addr}, {8'd0, exp_addr});
      check_val("mem_be", {30'd0, mem_be}, {30'd0, exp_be});
      if (exp_we || !exp_req) begin
        check_val("mem_wdata", {16'd0, mem_wdata}, {16'd0, exp_wdata});
      end
    end
  endtask

  // Controller: random 0..4 cycle latency, stray acks while no request.
  task automatic ctl_step();
    mem_ack   = 1'b0;
    mem_rdata = DW'($urandom);
    if (!ctl_busy && mem_req) begin
      ctl_busy = 1'b1;
      ctl_cnt  = $urandom_range(0, 4);
    end
    if (ctl_busy) begin
      if (ctl_cnt == 0) begin
        mem_ack  = 1'b1;
        ctl_busy = 1'b0;
        if (mem_we) begin
          if (mem_be[0]) mem_arr[mem_addr[3:0]][7:0]  = mem_wdata[7:0];
          if (mem_be[1]) mem_arr[mem_addr[3:0]][15:8] = mem_wdata[15:8];
        end else begin
          mem_rdata = mem_arr[mem_addr[3:0]];
        end
      end else begin
        ctl_cnt--;
      end
    end else if ($urandom_range(0, 7) == 0) begin
      mem_ack = 1'b1;
    end
  endtask

  task automatic run_cycles(input int n);
    logic [3:0] ack_s;
    for (int c = 0; c < n; c++) begin
      @(posedge clk_96M);
      #1;
      check_outputs();
      ack_s = {p3_ack, p2_ack, p1_ack, p0_ack};
      case (rst_mode)
        1:       reset = 1'b1;
        2:       reset = ($urandom_range(0, 199) == 0);
        default: reset = 1'b0;
      endcase
      case (dl_mode)
        1:       dl_active = 1'b1;
        2:       if ($urandom_range(0, 49) == 0) dl_active = ~dl_active;
        default: dl_active = 1'b0;
      endcase
      if (reset) begin
        for (int i = 0; i < 4; i++) begin
          ag_req[i]  = 1'b0;
          ag_done[i] = 1'b0;
        end
        ctl_busy  = 1'b0;
        mem_ack   = 1'($urandom_range(0, 1));
        mem_rdata = DW'($urandom);
      end else begin
        for (int i = 0; i < 4; i++) begin
          if (ack_s[i]) begin
            ag_done[i] = 1'b1;
          end else if (ag_done[i]) begin
            ag_done[i] = 1'b0;
            if ($urandom_range(0, 99) < renew_pct) new_req(i);
            else ag_req[i] = 1'b0;
          end else if (!ag_req[i] && $urandom_range(0, 99) < raise_pct[i]) begin
            new_req(i);
          end
        end
        ctl_step();
      end
      drive_ports();
      model_step();
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem_arr[i] = DW'($urandom);
    for (int i = 0; i < 4; i++) begin
      ag_req[i]    = 1'b0;
      ag_done[i]   = 1'b0;
      ag_addr[i]   = '0;
      raise_pct[i] = 0;
    end
    ag_wdata  = '0;
    ag_be     = 2'b00;
    renew_pct = 0;
    ctl_busy  = 1'b0;
    ctl_cnt   = 0;
    reset     = 1'b1;
    dl_active = 1'b0;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    rst_mode  = 1;
    dl_mode   = 0;
    drive_ports();
    model_step();
    run_cycles(3);

    // all three readers continuously requesting: strict 1,2,3 rotation
    rst_mode     = 0;
    raise_pct[1] = 100;
    raise_pct[2] = 100;
    raise_pct[3] = 100;
    renew_pct    = 100;
    run_cycles(60);

    // download active: only port 0 may be granted
    dl_mode      = 1;
    raise_pct[0] = 20;
    raise_pct[1] = 40;
    raise_pct[2] = 40;
    raise_pct[3] = 40;
    renew_pct    = 30;
    run_cycles(150);

    // mixed traffic with dl toggling and resets landing mid-transaction
    dl_mode      = 2;
    rst_mode     = 2;
    raise_pct[0] = 10;
    raise_pct[1] = 30;
    raise_pct[2] = 30;
    raise_pct[3] = 30;
    renew_pct    = 50;
    run_cycles(3000);

    rst_mode = 0;
    dl_mode  = 0;
    run_cycles(40);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
